// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter sharing one register-file port among NREQ requesters,
// with an optional per-requester lock for atomic read-modify-write sequences.
module regbus_rr_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 3,
    parameter int unsigned DW      = 2,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned LOCK_TO = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WE,
    input  logic [NREQ-1:0]    REQ_LOCK,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    RSP_VALID,
    output logic [DW-1:0]      RSP_DATA,
    output logic               WRITE,
    output logic               READ,
    output logic [AW-1:0]      ADDR,
    output logic [DW-1:0]      WRITE_DATA,
    input  logic [DW-1:0]      READ_DATA,
    output logic               BUSY
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned LW = $clog2(RD_LAT + 1);
    localparam int unsigned TW = $clog2(LOCK_TO + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

    state_e        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] cur;
    logic          cur_we;
    logic [LW-1:0] rd_cnt;
    logic          lock_held;
    logic [IW-1:0] lock_owner;
    logic [TW-1:0] lock_timer;

    logic          win_found;
    logic [IW-1:0] win_idx;
    int unsigned   cand;

    // A held lock restricts eligibility to its owner; otherwise search from ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (lock_held) begin
            win_found = REQ[lock_owner];
            win_idx   = lock_owner;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = (32'(ptr) + k) % NREQ;
                if (!win_found && REQ[IW'(cand)]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(cand);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= StIdle;
            ptr        <= '0;
            cur        <= '0;
            cur_we     <= 1'b0;
            rd_cnt     <= '0;
            lock_held  <= 1'b0;
            lock_owner <= '0;
            lock_timer <= '0;
            GNT        <= '0;
            RSP_VALID  <= '0;
            RSP_DATA   <= '0;
            WRITE      <= 1'b0;
            READ       <= 1'b0;
            ADDR       <= '0;
            WRITE_DATA <= '0;
            BUSY       <= 1'b0;
        end else begin
            GNT       <= '0;
            WRITE     <= 1'b0;
            READ      <= 1'b0;
            RSP_VALID <= '0;
            unique case (state)
                StIdle: begin
                    if (win_found) begin
                        state      <= StIssue;
                        BUSY       <= 1'b1;
                        cur        <= win_idx;
                        cur_we     <= REQ_WE[win_idx];
                        GNT        <= NREQ'(1) << win_idx;
                        WRITE      <= REQ_WE[win_idx];
                        READ       <= ~REQ_WE[win_idx];
                        ADDR       <= REQ_ADDR[32'(win_idx) * AW +: AW];
                        WRITE_DATA <= REQ_WDATA[32'(win_idx) * DW +: DW];
                        lock_timer <= '0;
                        if (REQ_LOCK[win_idx]) begin
                            lock_held  <= 1'b1;
                            lock_owner <= win_idx;
                        end else begin
                            lock_held <= 1'b0;
                            ptr       <= IW'((32'(win_idx) + 1) % NREQ);
                        end
                    end else if (lock_held) begin
                        // An owner that stays away too long forfeits the lock.
                        if (lock_timer == TW'(LOCK_TO - 1)) begin
                            lock_held  <= 1'b0;
                            lock_timer <= '0;
                        end else begin
                            lock_timer <= lock_timer + TW'(1);
                        end
                    end
                end
                StIssue: begin
                    if (cur_we) begin
                        state <= StIdle;
                        BUSY  <= 1'b0;
                    end else begin
                        state  <= StWaitRd;
                        rd_cnt <= '0;
                    end
                end
                StWaitRd: begin
                    if (rd_cnt == LW'(RD_LAT - 1)) begin
                        state     <= StIdle;
                        BUSY      <= 1'b0;
                        RSP_VALID <= NREQ'(1) << cur;
                        RSP_DATA  <= READ_DATA;
                    end else begin
                        rd_cnt <= rd_cnt + LW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Directed self-checking bench for regbus_rr_arbiter (NREQ=4, RD_LAT=2, LOCK_TO=8).
module tb_regbus_rr_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned AW      = 3;
    localparam int unsigned DW      = 2;
    localparam int unsigned RD_LAT  = 2;
    localparam int unsigned LOCK_TO = 8;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_WE;
    logic [NREQ-1:0]    REQ_LOCK;
    logic [NREQ*AW-1:0] REQ_ADDR;
    logic [NREQ*DW-1:0] REQ_WDATA;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    RSP_VALID;
    logic [DW-1:0]      RSP_DATA;
    logic               WRITE;
    logic               READ;
    logic [AW-1:0]      ADDR;
    logic [DW-1:0]      WRITE_DATA;
    logic [DW-1:0]      READ_DATA;
    logic               BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    regbus_rr_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .RD_LAT  (RD_LAT),
        .LOCK_TO (LOCK_TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .REQ_WE     (REQ_WE),
        .REQ_LOCK   (REQ_LOCK),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .GNT        (GNT),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .WRITE      (WRITE),
        .READ       (READ),
        .ADDR       (ADDR),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST       = 1'b1;
        REQ       = '0;
        REQ_WE    = '0;
        REQ_LOCK  = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        READ_DATA = '0;
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] i, input logic we, input logic lock,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int unsigned ab;
        int unsigned db;
        ab = 32'(i) * AW;
        db = 32'(i) * DW;
        REQ[i]               = 1'b1;
        REQ_WE[i]            = we;
        REQ_LOCK[i]          = lock;
        REQ_ADDR[ab +: AW]   = addr;
        REQ_WDATA[db +: DW]  = wdata;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({GNT, RSP_VALID, WRITE, READ, ADDR, WRITE_DATA, RSP_DATA, BUSY} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {GNT, RSP_VALID, WRITE, READ, ADDR, WRITE_DATA, RSP_DATA, BUSY});
        end
        RST = 1'b1;
        REQ = 4'b1111;
        next_cycle();
        n_checks++;
        if ({GNT, BUSY} !== 5'd0) begin
            n_fail++; $display("FAIL reset_dominates: got %b expected 00000", {GNT, BUSY});
        end
    endtask

    task automatic test_write();
        apply_reset();
        drive_req(2'd2, 1'b1, 1'b0, 3'd0, 2'b11);
        REQ_ADDR[2:0]  = 3'd5;
        REQ_WDATA[1:0] = 2'b01;
        next_cycle(); // cycle 1
        n_checks++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt: got %b expected 0100", GNT); end
        n_checks++; if ({WRITE, READ} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes: got %b expected 10", {WRITE, READ}); end
        n_checks++; if (ADDR !== 3'd0) begin n_fail++; $display("FAIL wr_addr: got %0d expected 0", ADDR); end
        n_checks++; if (WRITE_DATA !== 2'd3) begin n_fail++; $display("FAIL wr_data: got %0d expected 3", WRITE_DATA); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL wr_busy_issue: got %b expected 1", BUSY); end
        REQ = '0;
        next_cycle(); // cycle 2
        n_checks++; if ({BUSY, WRITE, GNT} !== 6'd0) begin n_fail++; $display("FAIL wr_idle_after: got %b expected 000000", {BUSY, WRITE, GNT}); end
        drive_req(2'd0, 1'b1, 1'b0, 3'd1, 2'd1);
        drive_req(2'd3, 1'b1, 1'b0, 3'd6, 2'd2);
        next_cycle(); // cycle 3: ptr=3 so requester 3 wins
        n_checks++; if (GNT !== 4'b1000) begin n_fail++; $display("FAIL wr_ptr_next: got %b expected 1000", GNT); end
        n_checks++; if ({ADDR, WRITE_DATA} !== {3'd6, 2'd2}) begin n_fail++; $display("FAIL wr_ptr_fields: got %b expected 11010", {ADDR, WRITE_DATA}); end
        REQ = '0;
        next_cycle();
    endtask

    task automatic test_read();
        apply_reset();
        READ_DATA = 2'b01;
        drive_req(2'd1, 1'b0, 1'b0, 3'd0, 2'b11);
        REQ_ADDR[8:6] = 3'd7;
        next_cycle(); // cycle 1
        n_checks++; if ({WRITE, READ} !== 2'b01) begin n_fail++; $display("FAIL rd_strobes: got %b expected 01", {WRITE, READ}); end
        n_checks++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL rd_gnt: got %b expected 0010", GNT); end
        n_checks++; if (ADDR !== 3'd0) begin n_fail++; $display("FAIL rd_addr: got %0d expected 0", ADDR); end
        REQ = '0;
        next_cycle(); // cycle 2
        n_checks++; if ({BUSY, READ, RSP_VALID} !== 6'b100000) begin n_fail++; $display("FAIL rd_wait: got %b expected 100000", {BUSY, READ, RSP_VALID}); end
        next_cycle(); // cycle 3
        READ_DATA = 2'b10;
        n_checks++; if (RSP_VALID !== 4'b0000) begin n_fail++; $display("FAIL rd_early_rsp: got %b expected 0000", RSP_VALID); end
        next_cycle(); // cycle 4
        READ_DATA = 2'b01;
        n_checks++; if (RSP_VALID !== 4'b0010) begin n_fail++; $display("FAIL rd_rsp_valid: got %b expected 0010", RSP_VALID); end
        n_checks++; if (RSP_DATA !== 2'd2) begin n_fail++; $display("FAIL rd_rsp_data: got %0d expected 2", RSP_DATA); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rd_busy_done: got %b expected 0", BUSY); end
        next_cycle(); // cycle 5
        n_checks++; if ({RSP_VALID, RSP_DATA} !== 6'b000010) begin n_fail++; $display("FAIL rd_rsp_hold: got %b expected 000010", {RSP_VALID, RSP_DATA}); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt [9];
        exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        apply_reset();
        for (int i = 0; i < 4; i++) drive_req(2'(i), 1'b1, 1'b0, 3'(i), 2'(i));
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            n_checks++;
            if (GNT !== exp_gnt[c-1]) begin
                n_fail++;
                $display("FAIL fair_cycle%0d: got %b expected %b", c, GNT, exp_gnt[c-1]);
            end
            // Requester 0 keeps requesting; the others drop after their grant.
            if (exp_gnt[c-1] != 4'b0000 && exp_gnt[c-1] != 4'b0001) REQ = REQ & ~exp_gnt[c-1];
        end
        REQ = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lock_rmw();
        apply_reset();
        READ_DATA = 2'b11;
        drive_req(2'd1, 1'b0, 1'b1, 3'd3, 2'd0);
        next_cycle(); // cycle 1
        n_checks++; if ({GNT, READ} !== 5'b00101) begin n_fail++; $display("FAIL lk_rd_gnt: got %b expected 00101", {GNT, READ}); end
        REQ[1] = 1'b0;
        drive_req(2'd0, 1'b1, 1'b0, 3'd1, 2'd1);
        drive_req(2'd2, 1'b1, 1'b0, 3'd2, 2'd2);
        next_cycle(); // cycle 2
        drive_req(2'd1, 1'b1, 1'b0, 3'd3, 2'b10);
        n_checks++; if (GNT !== 4'b0000) begin n_fail++; $display("FAIL lk_wait2: got %b expected 0000", GNT); end
        next_cycle(); // cycle 3
        n_checks++; if (GNT !== 4'b0000) begin n_fail++; $display("FAIL lk_wait3: got %b expected 0000", GNT); end
        next_cycle(); // cycle 4
        n_checks++; if ({RSP_VALID, RSP_DATA} !== 6'b001011) begin n_fail++; $display("FAIL lk_rsp: got %b expected 001011", {RSP_VALID, RSP_DATA}); end
        next_cycle(); // cycle 5
        n_checks++; if (GNT !== 4'b0010) begin n_fail++; $display("FAIL lk_owner_wr: got %b expected 0010", GNT); end
        n_checks++; if ({WRITE, ADDR, WRITE_DATA} !== 6'b101110) begin n_fail++; $display("FAIL lk_owner_fields: got %b expected 101110", {WRITE, ADDR, WRITE_DATA}); end
        REQ[1] = 1'b0;
        next_cycle(); // cycle 6
        next_cycle(); // cycle 7
        n_checks++; if (GNT !== 4'b0100) begin n_fail++; $display("FAIL lk_after_release: got %b expected 0100", GNT); end
        REQ[2] = 1'b0;
        next_cycle(); // cycle 8
        next_cycle(); // cycle 9
        n_checks++; if (GNT !== 4'b0001) begin n_fail++; $display("FAIL lk_last: got %b expected 0001", GNT); end
        REQ = '0;
        next_cycle();
    endtask

    task automatic test_lock_timeout();
        apply_reset();
        drive_req(2'd3, 1'b1, 1'b1, 3'd4, 2'd1);
        next_cycle(); // cycle 1
        n_checks++; if (GNT !== 4'b1000) begin n_fail++; $display("FAIL to_lock_gnt: got %b expected 1000", GNT); end
        REQ[3]      = 1'b0;
        REQ_LOCK[3] = 1'b0;
        drive_req(2'd0, 1'b1, 1'b0, 3'd2, 2'd3);
        for (int c = 2; c <= 10; c++) begin
            next_cycle();
            n_checks++;
            if (GNT !== 4'b0000) begin
                n_fail++; $display("FAIL to_blocked_cycle%0d: got %b expected 0000", c, GNT);
            end
        end
        next_cycle(); // cycle 11
        n_checks++; if ({GNT, ADDR} !== 7'b0001010) begin n_fail++; $display("FAIL to_released_gnt: got %b expected 0001010", {GNT, ADDR}); end
        REQ = '0;
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive_req(2'd2, 1'b0, 1'b0, 3'd1, 2'd0);
        next_cycle(); // cycle 1
        n_checks++; if ({GNT, READ, ADDR} !== 8'b01001001) begin n_fail++; $display("FAIL rm_issue: got %b expected 01001001", {GNT, READ, ADDR}); end
        REQ = '0;
        next_cycle(); // cycle 2, WAIT_RD
        RST       = 1'b1;
        READ_DATA = 2'b11;
        next_cycle(); // cycle 3
        n_checks++;
        if ({GNT, RSP_VALID, WRITE, READ, ADDR, WRITE_DATA, RSP_DATA, BUSY} !== 18'd0) begin
            n_fail++;
            $display("FAIL rm_outputs_zero: got %b expected all zero",
                     {GNT, RSP_VALID, WRITE, READ, ADDR, WRITE_DATA, RSP_DATA, BUSY});
        end
        RST = 1'b0;
        drive_req(2'd0, 1'b1, 1'b0, 3'd0, 2'd0);
        drive_req(2'd3, 1'b1, 1'b0, 3'd7, 2'd1);
        next_cycle(); // cycle 4
        n_checks++; if (GNT !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr_reset: got %b expected 0001", GNT); end
        n_checks++; if (RSP_VALID !== 4'b0000) begin n_fail++; $display("FAIL rm_no_rsp4: got %b expected 0000", RSP_VALID); end
        REQ[0] = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            next_cycle();
            n_checks++;
            if (RSP_VALID !== 4'b0000) begin
                n_fail++; $display("FAIL rm_no_rsp_cycle%0d: got %b expected 0000", c, RSP_VALID);
            end
            if (c == 6) begin
                n_checks++;
                if (GNT !== 4'b1000) begin n_fail++; $display("FAIL rm_next_gnt: got %b expected 1000", GNT); end
                REQ = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_lock_rmw();
        test_lock_timeout();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/regbus_rr_arbiter.md
Name: regbus_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single register-file access port (WRITE/READ/ADDR/WRITE_DATA/READ_DATA) among NREQ requesters. It issues one access at a time and returns read data to the owning requester. A lock option gives one requester atomic read-modify-write sequences. It sits between the control agents and the small register bank.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 3, register address width
DW, 2, register data width
RD_LAT, 1, cycles from READ-high cycle to READ_DATA valid (>=1)
LOCK_TO, 8, idle cycles after which an unused lock is released

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
REQ  in  NREQ  per-requester access request, level
REQ_WE  in  NREQ  1=write, 0=read
REQ_LOCK  in  NREQ  hold ownership after this access
REQ_ADDR  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
REQ_WDATA  in  NREQ*DW  packed write data
GNT  out  NREQ  one-hot accept pulse
RSP_VALID  out  NREQ  one-hot read-response pulse
RSP_DATA  out  DW  read data, valid with RSP_VALID
WRITE  out  1  register-port write strobe
READ  out  1  register-port read strobe
ADDR  out  AW  register-port address
WRITE_DATA  out  DW  register-port write data
READ_DATA  in  DW  register-port read data
BUSY  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-high, on CLK. All outputs are 0, state=IDLE, ptr=0, lock cleared, lock timer 0. RST mid-operation abandons the access; no RSP_VALID is produced for it.
- All outputs are registered.
- State IDLE, cycle t: the winner is the first i with REQ[i]=1, searching from ptr upward with wrap.
  - If a lock is held by owner k: only REQ[k] is eligible.
  - If no eligible request: stay in IDLE. If a lock is held, increment the lock timer; when it reaches LOCK_TO, clear the lock and zero the timer.
- Cycle t+1 (state ISSUE):
  - GNT[i]=1.
  - WRITE=REQ_WE[i] and READ=~REQ_WE[i], as captured at t.
  - ADDR and WRITE_DATA carry values captured at t.
  - ptr=(i+1) mod NREQ unless REQ_LOCK[i]=1, in which case lock owner=i and timer=0. REQ_LOCK[i]=0 from the owner releases the lock.
- ISSUE lasts exactly one cycle. A write then goes to IDLE at t+2. A read goes to WAIT_RD, which counts RD_LAT cycles; READ_DATA is sampled at the end of cycle t+1+RD_LAT.
- Cycle t+2+RD_LAT: RSP_VALID[i]=1, RSP_DATA=sampled value, state=IDLE. Arbitration for the next access happens in this same cycle.
- Requester obligations:
  - Hold REQ and its fields stable until GNT is seen.
  - REQ may remain high during the GNT cycle and is ignored outside IDLE.
  - REQ must be low (or carry a new request) from the cycle after GNT.
- Throughput: a write takes 2 cycles per access; a read takes 2+RD_LAT.
- WRITE/READ/GNT are low in every cycle other than ISSUE. RSP_VALID is low except in the response cycle. RSP_DATA holds its last value.
- REQ_WE, REQ_ADDR and REQ_WDATA of non-winning requesters have no effect.

Test Plan:
1. Write, RD_LAT=1: REQ=4'b0100, WE[2]=1, ADDR2=0, WDATA2=2'b11 at cycle 0 -> cycle 1: GNT=4'b0100, WRITE=1, ADDR=0, WRITE_DATA=3; cycle 2: BUSY=0, ptr=3.
2. Read, RD_LAT=2: requester 1 reads ADDR=0, READ_DATA=2'b10 in cycle 3 -> cycle 1: READ=1, GNT=4'b0010; cycle 4: RSP_VALID=4'b0010, RSP_DATA=2.
3. Fairness: all four REQ held with writes, each dropped after its GNT -> grants 0,1,2,3 at cycles 1,3,5,7. Requester 0 re-requests after its grant -> its next grant comes after requester 3's.
4. Lock RMW: requester 1 reads with LOCK=1 while requesters 0 and 2 request -> requester 1's following write is granted before 0 or 2. That write has LOCK=0 -> next grant goes to 2.
5. Lock timeout, LOCK_TO=8: requester 3 takes lock then drops REQ, requester 0 requests -> no GNT for 8 idle cycles, then GNT=4'b0001.
6. Reset mid-read: RST in the WAIT_RD cycle -> next cycle all outputs 0, no RSP_VALID ever, a new REQ[0] is granted from ptr=0.
